// File: rtl/adc_frame_align_ctrl_if.sv
// Bus between the LVDS ADC deserializer and its frame alignment controller.
// master drives the deserialized words and realign; slave is the controller.
interface adc_frame_align_ctrl_if #(
    parameter int unsigned FRAME_W = 7
);
    logic [FRAME_W-1:0] frame_bits;
    logic [27:0]        sample_bits;
    logic               realign;
    logic               bitslip;
    logic               locked;
    logic               data_we;
    logic [31:0]        data;
    logic [3:0]         slip_count;
    logic [7:0]         lock_loss_count;
    logic               align_error;

    modport master (
        output frame_bits, sample_bits, realign,
        input  bitslip, locked, data_we, data, slip_count, lock_loss_count, align_error
    );

    modport slave (
        input  frame_bits, sample_bits, realign,
        output bitslip, locked, data_we, data, slip_count, lock_loss_count, align_error
    );
endinterface

// File: rtl/adc_frame_align_ctrl.sv
// Frame-lane alignment controller for a 7:1 LVDS ADC deserializer: issues BITSLIP
// until the frame word is stable, tracks lock, and gates the sample stream.
module adc_frame_align_ctrl #(
    parameter int unsigned        FRAME_W       = 7,
    parameter logic [FRAME_W-1:0] FRAME_PATTERN = 7'b1111000,
    parameter int unsigned        SETTLE_CYCLES = 4,
    parameter int unsigned        MATCH_COUNT   = 16,
    parameter int unsigned        LOSS_THRESH   = 4,
    parameter int unsigned        MAX_SLIPS     = 14,
    parameter int unsigned        RETRY_CYCLES  = 1024
) (
    input logic                    clk_adc,
    input logic                    reset,
    adc_frame_align_ctrl_if.slave  bus
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned MissW   = $clog2(LOSS_THRESH + 1);
    localparam int unsigned RetryW  = $clog2(RETRY_CYCLES + 1);

    typedef enum logic [2:0] {StSettle, StCheck, StSlip, StLocked, StFail} state_e;

    state_e             state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [MatchW-1:0]  match_q, match_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic [3:0]         slip_q, slip_d;
    logic [7:0]         loss_q, loss_d;
    logic               data_we_q;
    logic [31:0]        data_q;
    logic               frame_match;

    assign frame_match = (bus.frame_bits == FRAME_PATTERN);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        miss_d   = miss_q;
        retry_d  = retry_q;
        slip_d   = slip_q;
        loss_d   = loss_q;
        unique case (state_q)
            StSettle: begin
                if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    match_d  = '0;
                    state_d  = StCheck;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StCheck: begin
                if (frame_match) begin
                    if (match_q == MatchW'(MATCH_COUNT - 1)) begin
                        miss_d  = '0;
                        state_d = StLocked;
                    end else begin
                        match_d = match_q + MatchW'(1);
                    end
                end else if (slip_q == 4'(MAX_SLIPS)) begin
                    retry_d = '0;
                    state_d = StFail;
                end else begin
                    state_d = StSlip;
                end
            end
            StSlip: begin
                slip_d   = slip_q + 4'd1;
                settle_d = '0;
                state_d  = StSettle;
            end
            StLocked: begin
                if (frame_match) begin
                    miss_d = '0;
                end else if (miss_q == MissW'(LOSS_THRESH - 1)) begin
                    miss_d   = '0;
                    slip_d   = '0;
                    settle_d = '0;
                    state_d  = StSettle;
                    if (loss_q != 8'hff) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else begin
                    miss_d = miss_q + MissW'(1);
                end
            end
            StFail: begin
                if (retry_q == RetryW'(RETRY_CYCLES - 1)) begin
                    retry_d  = '0;
                    slip_d   = '0;
                    settle_d = '0;
                    state_d  = StSettle;
                end else begin
                    retry_d = retry_q + RetryW'(1);
                end
            end
            default: begin
                state_d = StSettle;
            end
        endcase
        // A realign request overrides every transition above; the lock-loss count is untouched.
        if (bus.realign) begin
            state_d  = StSettle;
            settle_d = '0;
            match_d  = '0;
            miss_d   = '0;
            retry_d  = '0;
            slip_d   = '0;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state_q   <= StSettle;
            settle_q  <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            retry_q   <= '0;
            slip_q    <= '0;
            loss_q    <= '0;
            data_we_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            retry_q   <= retry_d;
            slip_q    <= slip_d;
            loss_q    <= loss_d;
            data_we_q <= (state_q == StLocked) && frame_match;
            data_q    <= {2'b00, bus.sample_bits[27:14], 2'b00, bus.sample_bits[13:0]};
        end
    end

    assign bus.bitslip         = (state_q == StSlip);
    assign bus.locked          = (state_q == StLocked);
    assign bus.align_error     = (state_q == StFail);
    assign bus.slip_count      = slip_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.data_we         = data_we_q;
    assign bus.data            = data_q;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Bench for adc_frame_align_ctrl: a rotating-frame deserializer plant plus a
// behavioural model of the alignment rules, checked every cycle and at directed points.
module tb_adc_frame_align_ctrl;

    localparam int unsigned FRAME_W = 7;
    localparam logic [6:0]  PAT     = 7'b1111000;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned MATCH   = 16;
    localparam int unsigned LOSS    = 4;
    localparam int unsigned MAXS    = 14;
    localparam int unsigned RETRY   = 1024;

    logic clk_adc = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_adc = ~clk_adc;

    adc_frame_align_ctrl_if #(.FRAME_W(FRAME_W)) bus ();

    adc_frame_align_ctrl #(
        .FRAME_W      (FRAME_W),
        .FRAME_PATTERN(PAT),
        .SETTLE_CYCLES(SETTLE),
        .MATCH_COUNT  (MATCH),
        .LOSS_THRESH  (LOSS),
        .MAX_SLIPS    (MAXS),
        .RETRY_CYCLES (RETRY)
    ) dut (
        .clk_adc(clk_adc),
        .reset  (reset),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Deserializer plant: frame lane is PAT rotated left by rot; each BITSLIP undoes one bit.
    int         rot     = 0;
    bit         bad_en  = 1'b0;
    logic [6:0] bad_word = 7'h00;

    // Reference model state, phrased as the alignment rules rather than registers.
    typedef enum {Waiting, Hunting, Slipping, Aligned, GaveUp} phase_e;
    phase_e      m_phase = Waiting;
    int          m_wait, m_run, m_miss, m_retry, m_slips, m_losses;
    bit          m_we;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] rotl(input int r);
        logic [13:0] d;
        d = {PAT, PAT};
        return d[13-r -: 7];
    endfunction

    function automatic logic [6:0] rand_bad();
        logic [6:0] w;
        do w = 7'($urandom); while (w == PAT);
        return w;
    endfunction

    function automatic void model_step();
        bit hit;
        hit = (bus.frame_bits == PAT);
        if (reset) begin
            m_phase = Waiting; m_wait = SETTLE; m_run = 0; m_miss = 0; m_retry = 0;
            m_slips = 0; m_losses = 0; m_we = 1'b0; m_data = '0;
            return;
        end
        m_we   = (m_phase == Aligned) && hit;
        m_data = {2'b00, bus.sample_bits[27:14], 2'b00, bus.sample_bits[13:0]};
        case (m_phase)
            Waiting: begin
                m_wait--;
                if (m_wait == 0) begin m_phase = Hunting; m_run = 0; end
            end
            Hunting: begin
                if (hit) begin
                    m_run++;
                    if (m_run == MATCH) begin m_phase = Aligned; m_miss = 0; end
                end else if (m_slips == MAXS) begin
                    m_phase = GaveUp; m_retry = RETRY;
                end else begin
                    m_phase = Slipping;
                end
            end
            Slipping: begin m_slips++; m_phase = Waiting; m_wait = SETTLE; end
            Aligned: begin
                if (hit) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_phase = Waiting; m_wait = SETTLE; m_slips = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
            end
            GaveUp: begin
                m_retry--;
                if (m_retry == 0) begin m_phase = Waiting; m_wait = SETTLE; m_slips = 0; end
            end
            default: ;
        endcase
        if (bus.realign) begin
            m_phase = Waiting; m_wait = SETTLE; m_slips = 0; m_run = 0; m_miss = 0;
        end
    endfunction

    task automatic check_outputs();
        chk("bitslip", 32'(bus.bitslip), 32'(m_phase == Slipping));
        chk("locked", 32'(bus.locked), 32'(m_phase == Aligned));
        chk("align_error", 32'(bus.align_error), 32'(m_phase == GaveUp));
        chk("slip_count", 32'(bus.slip_count), m_slips);
        chk("lock_loss_count", 32'(bus.lock_loss_count), m_losses);
        chk("data_we", 32'(bus.data_we), 32'(m_we));
        chk("data", bus.data, m_data);
    endtask

    // One clock: drive inputs, let the edge happen, step the model, check, update the plant.
    task automatic cyc();
        bus.frame_bits  = bad_en ? bad_word : rotl(rot);
        bus.sample_bits = 28'($urandom);
        @(posedge clk_adc);
        model_step();
        #1;
        check_outputs();
        if (bus.bitslip === 1'b1) rot = (rot == 0) ? int'(FRAME_W) - 1 : rot - 1;
    endtask

    task automatic realign_pulse();
        bus.realign = 1'b1;
        cyc();
        bus.realign = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bitslip"}, 32'(bus.bitslip), 0);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_data_we"}, 32'(bus.data_we), 0);
        chk({tag, "_data"}, bus.data, 0);
        chk({tag, "_slip_count"}, 32'(bus.slip_count), 0);
        chk({tag, "_loss"}, 32'(bus.lock_loss_count), 0);
        chk({tag, "_align_error"}, 32'(bus.align_error), 0);
    endtask

    task automatic wait_lock(input string tag, input int exp_pulses, input int exp_edges);
        int edges = 0;
        int pulses = 0;
        int last = 0;
        int bad_gap = 0;
        while (bus.locked !== 1'b1 && edges < 2000) begin
            cyc();
            edges++;
            if (bus.bitslip === 1'b1) begin
                if (pulses > 0 && edges - last != int'(SETTLE) + 2) bad_gap++;
                pulses++;
                last = edges;
            end
        end
        chk({tag, "_locked"}, 32'(bus.locked), 1);
        chk({tag, "_edges"}, edges, exp_edges);
        chk({tag, "_pulses"}, pulses, exp_pulses);
        chk({tag, "_gaps"}, bad_gap, 0);
        chk({tag, "_slip_count"}, 32'(bus.slip_count), exp_pulses);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        int zeros;
        bit stay;

        bus.realign     = 1'b0;
        bus.frame_bits  = '0;
        bus.sample_bits = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) cyc();
        chk_zero("reset");
        reset = 1'b0;

        // Aligned from the start: lock after SETTLE+MATCH edges, data_we one cycle later
        wait_lock("s1", 0, int'(SETTLE + MATCH));
        chk("s1_we_lag", 32'(bus.data_we), 0);
        cyc();
        chk("s1_data_we", 32'(bus.data_we), 1);
        chk("s1_data", bus.data,
            {2'b00, bus.sample_bits[27:14], 2'b00, bus.sample_bits[13:0]});

        // Rotated frame lane: one bitslip per bit of rotation
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? 3 : int'($urandom_range(1, 6));
            rot = r;
            realign_pulse();
            wait_lock("s2", r, int'(SETTLE + MATCH) + r * int'(SETTLE + 2));
        end

        // Stuck frame lane: MAXS slips, RETRY cycles of error, then a fresh attempt
        bad_en = 1'b1;
        bad_word = 7'h00;
        realign_pulse();
        n = 0;
        while (bus.align_error !== 1'b1 && n < 500) begin
            cyc();
            if (bus.bitslip === 1'b1) n++;
        end
        chk("s3_slips", n, MAXS);
        n = 0;
        while (bus.align_error === 1'b1 && n < 2000) begin
            n++;
            cyc();
        end
        chk("s3_fail_len", n, RETRY);
        chk("s3_slip_clr", 32'(bus.slip_count), 0);
        n = 0;
        while (bus.bitslip !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("s3_restart", n, SETTLE + 1);

        // Short glitch keeps lock, a long one drops it
        bad_en = 1'b0;
        rot = 0;
        realign_pulse();
        wait_lock("s4", 0, int'(SETTLE + MATCH));
        repeat (2) cyc();
        zeros = 0;
        stay = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bad_en = (i < 3);
            bad_word = rand_bad();
            cyc();
            if (bus.data_we !== 1'b1) zeros++;
            if (bus.locked !== 1'b1) stay = 1'b0;
        end
        chk("s4_we_zeros", zeros, 3);
        chk("s4_stay_locked", 32'(stay), 1);
        bad_en = 1'b1;
        for (int i = 0; i < int'(LOSS); i++) begin
            bad_word = rand_bad();
            cyc();
        end
        chk("s4_lost", 32'(bus.locked), 0);
        chk("s4_loss_count", 32'(bus.lock_loss_count), 1);
        bad_en = 1'b0;
        wait_lock("s4_relock", 0, int'(SETTLE + MATCH));

        // Realign while locked
        repeat (2) cyc();
        realign_pulse();
        chk("s5_unlocked", 32'(bus.locked), 0);
        chk("s5_loss_same", 32'(bus.lock_loss_count), 1);
        wait_lock("s5", 0, int'(SETTLE + MATCH));

        // Reset mid-SLIP and mid-LOCKED
        rot = 2;
        realign_pulse();
        n = 0;
        while (bus.bitslip !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("s6_in_slip", 32'(bus.bitslip), 1);
        reset = 1'b1;
        cyc();
        chk_zero("s6_rst_slip");
        cyc();
        reset = 1'b0;
        rot = 0;
        wait_lock("s6", 0, int'(SETTLE + MATCH));
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk_zero("s6_rst_locked");
        reset = 1'b0;

        // Random traffic: glitches, realign pulses and alignment jumps against the model
        for (int i = 0; i < 1500; i++) begin
            bus.realign = ($urandom_range(99) < 2);
            bad_en = ($urandom_range(99) < 4);
            bad_word = rand_bad();
            if ($urandom_range(199) == 0) rot = int'($urandom_range(6));
            cyc();
        end
        bus.realign = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_frame_align_ctrl.md
Name: adc_frame_align_ctrl

Overview:
- Alignment controller for the 7:1 LVDS ADC deserializer (2 data lanes per channel plus a frame lane, 35 parallel bits per clk_adc).
- Sequences BITSLIP until the deserialized frame lane matches a fixed pattern for a run of consecutive words, then declares lock.
- Monitors lock continuously and re-aligns on loss.
- Gates the channel A/B sample stream so downstream FIFOs only see words captured while locked.

Parameters:
FRAME_W, 7, width of the deserialized frame lane word
FRAME_PATTERN, 7'b1111000, frame-lane word expected when aligned
SETTLE_CYCLES, 4, clk_adc cycles waited after each bitslip before comparing (≥1)
MATCH_COUNT, 16, consecutive matching frame words required to declare lock (≥1)
LOSS_THRESH, 4, consecutive mismatches in LOCKED that drop lock (≥1)
MAX_SLIPS, 14, bitslips tried before declaring alignment failure (2×FRAME_W)
RETRY_CYCLES, 1024, wait in FAIL state before a new alignment attempt

Ports:
clk_adc  in  1  divided ADC clock; all logic on its rising edge
reset  in  1  synchronous, active-high
frame_bits  in  FRAME_W  deserialized frame lane, bits [34:28] of deserializer output
sample_bits  in  28  deserialized data; [13:0] chA, [27:14] chB
realign  in  1  single-cycle request; forces a fresh alignment from any state
bitslip  out  1  one-cycle pulse to deserializer BITSLIP
locked  out  1  high while in LOCKED state
data_we  out  1  output word valid
data  out  32  {2'b0,chB,2'b0,chA}, registered
slip_count  out  4  bitslips issued in current attempt
lock_loss_count  out  8  saturating count of LOCKED->SETTLE transitions
align_error  out  1  high while in FAIL state

Behaviour:
- Reset: state=SETTLE; all counters 0; bitslip=0, locked=0, data_we=0, data=0, align_error=0, slip_count=0, lock_loss_count=0. lock_loss_count is cleared only by reset.
- SETTLE: increment settle_cnt each cycle; at SETTLE_CYCLES-1, clear settle_cnt and match_cnt, go CHECK.
- CHECK, frame_bits==FRAME_PATTERN: match_cnt++. On the MATCH_COUNT-th consecutive match, go LOCKED; locked rises the next cycle.
- CHECK, mismatch: if slip_count==MAX_SLIPS go FAIL; else go SLIP.
- SLIP: bitslip=1 for exactly this one cycle; slip_count++; go SETTLE. bitslip is never asserted on two consecutive cycles.
- LOCKED, match: miss_cnt=0.
- LOCKED, mismatch: miss_cnt++. On the LOSS_THRESH-th consecutive mismatch:
  - locked deasserts;
  - lock_loss_count increments (saturates at 255);
  - slip_count clears;
  - go SETTLE.
- FAIL: align_error=1; retry_cnt counts to RETRY_CYCLES-1, then slip_count=0 and go SETTLE.
- realign: in any state, next state=SETTLE; slip_count, match_cnt, miss_cnt, retry_cnt cleared; locked drops next cycle. No lock_loss_count increment. realign takes priority over every other transition. realign during SLIP still completes that cycle's bitslip pulse.
- Data path, registered, 1-cycle latency: data_we <= locked_state & (frame_bits==FRAME_PATTERN); data <= {2'b0,sample_bits[27:14],2'b0,sample_bits[13:0]} every cycle. data_we=0 on any mismatching word even while locked.
- Simultaneous events: a mismatch that also reaches LOSS_THRESH produces data_we=0 that cycle. When reset and realign are both high, reset wins.

Test Plan:
- Frame pattern correct from start, 20 words -> no bitslip; locked=1 on cycle SETTLE_CYCLES+MATCH_COUNT+1 (21) after reset release; data_we follows one cycle later; data=={2'b0,chB,2'b0,chA}.
- Model frame lane rotated by 3 bits, rotating one bit per bitslip pulse -> exactly 3 bitslip pulses, each separated by SETTLE_CYCLES+2 cycles; then locked=1, slip_count=3.
- Frame lane stuck at 7'h00 -> 14 bitslip pulses, then align_error=1 for 1024 cycles; then slip_count=0 and SLIP sequence restarts.
- While locked, inject 3 bad frame words then good -> locked stays 1, data_we=0 for those 3 words only. Inject 4 consecutive bad words -> locked=0, lock_loss_count=1, realignment starts.
- Pulse realign while locked -> locked=0 next cycle, lock_loss_count unchanged, re-lock after 21 cycles with a correct pattern.
- Assert reset mid-SLIP and mid-LOCKED -> all outputs 0 next cycle, no residual bitslip pulse.
